split: RTL and testbench
========================

# split

Address-decoded 1-to-N bus splitter for the interconnect's native valid/ready bus. It is the counterpart of the N-to-1 merge. A single master drives it, and it fans requests out to N slaves selected by the top address bits. It tracks the one outstanding request, so a response arriving on a later cycle is routed back from the correct slave. It sits between a CPU or master port and its peripheral/memory slaves.

## Interface
- N_SLAVES, 2, number of slave ports (>= 2)
- P_SLAVES, 1, select width; 2**P_SLAVES >= N_SLAVES
- ADDR_W, 32, address width
- DATA_W, 32, data width; REQ_W = 1+ADDR_W+DATA_W+DATA_W/8; RESP_W = DATA_W+1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m_req  in  REQ_W  master request {valid, addr, wdata, wstrb}, MSB first
- m_resp  out  RESP_W  master response {rdata, ready}
- s_req  out  N_SLAVES*REQ_W  slave requests; slave i occupies bits [(i+1)*REQ_W-1 : i*REQ_W]
- s_resp  in  N_SLAVES*RESP_W  slave responses, same packing
- busy  out  1  request outstanding (state != IDLE)
- prot_err  out  1  sticky: master valid seen while busy

## Operation
- Decode: sel = m_req.addr[ADDR_W-1 -: P_SLAVES]. in_range = (sel < N_SLAVES).
- States: IDLE, BUSY, ERR. sel_reg holds the slave index, P_SLAVES bits.
- Request forwarding (combinational): the request goes out only in IDLE with valid=1 and in_range. s_req slot sel = m_req; all other slots = 0. In BUSY, ERR, or when out of range, all s_req = 0.
- IDLE, valid, in_range, s_resp[sel].ready=1: zero-latency response. m_resp = s_resp[sel] in the same cycle; stay IDLE.
- IDLE, valid, in_range, ready=0: sel_reg <= sel; go to BUSY.
- IDLE, valid, !in_range: no slave accessed; go to ERR.
- BUSY: m_resp = s_resp[sel_reg] when that slot's ready=1, then go to IDLE. Otherwise m_resp = 0. ready from any other slave is ignored.
- ERR: m_resp = {rdata=0, ready=1} for exactly one cycle; go to IDLE.
- m_resp = 0, including rdata, in every cycle with no response. rdata is never passed through without ready.
- Master valid in BUSY or ERR is a protocol violation. The request is dropped and never forwarded; prot_err <= 1 and holds until reset.
- Ready for the request in the cycle the FSM leaves BUSY or ERR does not enable a new request in that same cycle. The next request is accepted from the following cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, sel_reg=0, prot_err=0.
- During reset, busy=0 and m_resp=0. s_req=0 unless a valid request is presented, since forwarding is combinational in IDLE.
- Master valid is a single-cycle pulse per request; at most one request is outstanding.
- Latency: 0 cycles when the slave answers in the valid cycle; otherwise ready appears on m_resp in the same cycle the slave asserts it. Out-of-range requests answer exactly 1 cycle after valid.
- busy rises the cycle after an accepted, non-immediate request, and falls the cycle after ready is returned.
- Reset mid-transaction: the outstanding request is abandoned. A late slave ready after reset release is ignored, since the FSM is in IDLE.

## Test plan
- N_SLAVES=2: read addr 0x0000_0010. Slave 0 ready in the same cycle with rdata 0xAABBCCDD -> m_resp = {0xAABBCCDD,1} that cycle, busy stays 0, s_req slot 1 = 0.
- Write addr 0x8000_0004, wdata 0x1234, wstrb 0xF. Slave 1 ready 3 cycles later -> only slot 1 valid, busy=1 for 3 cycles, m_resp ready=1 in the ready cycle, then busy=0.
- In BUSY for slave 1, slave 0 asserts ready with rdata 0xDEAD -> m_resp stays 0, busy stays 1.
- N_SLAVES=3, P_SLAVES=2, addr 0xC000_0000 -> no s_req valid; next cycle m_resp = {0,1}, then IDLE.
- Second valid issued while busy -> not forwarded; prot_err=1 and still 1 after 10 idle cycles; rst_n pulse clears it.
- Assert rst_n=0 mid-BUSY, release, then slave asserts ready -> m_resp=0, busy=0.

Source files
------------

// File: rtl/split_if.sv
// Bus bundle for the 1-to-N splitter: one master-side request/response pair plus
// the packed per-slave request/response vectors.
interface split_if #(
  parameter int N_SLAVES = 2,
  parameter int P_SLAVES = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;

  logic [REQ_W-1:0]           m_req;   // {valid, addr, wdata, wstrb}
  logic [RESP_W-1:0]          m_resp;  // {rdata, ready}
  logic [N_SLAVES*REQ_W-1:0]  s_req;
  logic [N_SLAVES*RESP_W-1:0] s_resp;

  // Environment side: drives the master request and the slave responses.
  modport master (
    output m_req,
    input  m_resp,
    input  s_req,
    output s_resp
  );

  // Splitter side.
  modport slave (
    input  m_req,
    output m_resp,
    output s_req,
    input  s_resp
  );
endinterface

// File: rtl/split.sv
// Address-decoded 1-to-N splitter: routes one request to the slave picked by the
// top address bits and steers that slave's response back, one request in flight.
module split #(
  parameter int N_SLAVES = 2,
  parameter int P_SLAVES = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  split_if.slave     bus,
  output logic       busy,
  output logic       prot_err,
  output logic [1:0] dbg_state
);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;
  localparam logic [P_SLAVES:0] N_SEL = (P_SLAVES + 1)'(N_SLAVES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [P_SLAVES-1:0]       sel, sel_reg, sel_nxt;
  logic                      valid, in_range, err_set;
  logic [RESP_W-1:0]         resp_arr [N_SLAVES];
  logic [RESP_W-1:0]         resp_sel, resp_held, m_resp_c;
  logic [N_SLAVES*REQ_W-1:0] s_req_c;

  // Handshake: a request is a one-cycle valid pulse; a response is any cycle whose
  // ready bit is 1, and rdata is zero whenever ready is 0.
  assign valid    = bus.m_req[REQ_W-1];
  assign sel      = bus.m_req[REQ_W-2 -: P_SLAVES];
  assign in_range = {1'b0, sel} < N_SEL;

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_resp
    assign resp_arr[i] = bus.s_resp[i*RESP_W +: RESP_W];
  end

  // resp_sel serves the zero-latency path, resp_held the registered BUSY path.
  always_comb begin
    resp_sel  = '0;
    resp_held = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel == P_SLAVES'(i))     resp_sel  = resp_arr[i];
      if (sel_reg == P_SLAVES'(i)) resp_held = resp_arr[i];
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_reg;
    s_req_c   = '0;
    m_resp_c  = '0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (in_range) begin
            for (int i = 0; i < N_SLAVES; i++) begin
              if (sel == P_SLAVES'(i)) s_req_c[i*REQ_W +: REQ_W] = bus.m_req;
            end
            if (resp_sel[0]) begin
              m_resp_c = resp_sel;
            end else begin
              state_nxt = BUSY;
              sel_nxt   = sel;
            end
          end else begin
            state_nxt = ERR;
          end
        end
      end
      BUSY: begin
        // Any valid here is dropped; only the latched slave can complete.
        err_set = valid;
        if (resp_held[0]) begin
          m_resp_c  = resp_held;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        err_set   = valid;
        m_resp_c  = {{DATA_W{1'b0}}, 1'b1};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_reg  <= '0;
      prot_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_reg <= sel_nxt;
      if (err_set) prot_err <= 1'b1;
    end
  end

  assign bus.s_req  = s_req_c;
  assign bus.m_resp = m_resp_c;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;
endmodule

// File: tb/tb_split.sv
// Randomized scoreboard bench for split with three slaves behind a 2-bit select,
// so the unused fourth select value exercises the out-of-range path.
module tb_split;
  localparam int N      = 3;
  localparam int P      = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int REQ_W  = 1 + AW + DW + DW / 8;
  localparam int RESP_W = DW + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, prot_err;
  logic [1:0] dbg_state;

  split_if #(.N_SLAVES(N), .P_SLAVES(P), .ADDR_W(AW), .DATA_W(DW)) bus ();

  split #(.N_SLAVES(N), .P_SLAVES(P), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .prot_err  (prot_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [RESP_W-1:0] exp_q[$];
  int  checks    = 0;
  int  failures  = 0;
  bit  exp_prot  = 1'b0;
  bit  pend_prot = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: a request reaches exactly the addressed slot when it is in range.
  function automatic logic [N*REQ_W-1:0] exp_sreq(input logic [REQ_W-1:0] req, input bit fwd);
    logic [N*REQ_W-1:0] v;
    int s;
    v = '0;
    s = int'(req[REQ_W-2 -: P]);
    if (fwd && req[REQ_W-1] && s < N) v[s*REQ_W +: REQ_W] = req;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (pend_prot) exp_prot = 1'b1;
    pend_prot = 1'b0;
  endtask

  // Slot sel gets the given ready/data; every other slot gets random chatter.
  task automatic set_slots(input int sel, input bit sel_rdy, input logic [DW-1:0] sel_data);
    for (int j = 0; j < N; j++) begin
      logic [RESP_W-1:0] r;
      if (j == sel) r = {sel_data, sel_rdy};
      else          r = {$urandom(), 1'($urandom_range(0, 1))};
      bus.s_resp[j*RESP_W +: RESP_W] = r;
    end
  endtask

  task automatic idle();
    step();
    bus.m_req = '0;
    set_slots(-1, 1'b0, '0);
    @(negedge clk);
    chk("busy_idle", busy, 1'b0);
    chk("s_req_idle", bus.s_req, '0);
  endtask

  task automatic do_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [3:0] wstrb, input int lat,
                        input logic [DW-1:0] rdata, input bit viol);
    logic [REQ_W-1:0] req;
    logic [REQ_W-1:0] vreq;
    int  sel;
    bit  inr;
    req  = {1'b1, addr, wdata, wstrb};
    vreq = {1'b1, $urandom(), $urandom(), 4'hF};
    sel  = int'(addr[AW-1 -: P]);
    inr  = (sel < N);
    step();
    chk("resp_latency", exp_q.size() == 0, 1'b1);
    bus.m_req = req;
    if (inr) begin
      exp_q.push_back({rdata, 1'b1});
      set_slots(sel, lat == 0, (lat == 0) ? rdata : $urandom());
    end else begin
      exp_q.push_back({{DW{1'b0}}, 1'b1});
      set_slots(-1, 1'b0, '0);
    end
    @(negedge clk);
    chk("s_req_fwd", bus.s_req, exp_sreq(req, 1'b1));
    chk("busy_accept", busy, 1'b0);
    if (!inr) begin
      step();
      bus.m_req = viol ? vreq : '0;
      if (viol) pend_prot = 1'b1;
      set_slots(-1, 1'b0, '0);
      @(negedge clk);
      chk("s_req_err", bus.s_req, '0);
      chk("busy_err", busy, 1'b1);
    end else begin
      for (int k = 1; k <= lat; k++) begin
        step();
        bus.m_req = (viol && k == 1) ? vreq : '0;
        if (viol && k == 1) pend_prot = 1'b1;
        set_slots(sel, k == lat, (k == lat) ? rdata : $urandom());
        @(negedge clk);
        chk("s_req_busy", bus.s_req, '0);
        chk("busy_wait", busy, 1'b1);
      end
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    bus.m_req  = '0;
    bus.s_resp = '0;
    exp_q.delete();
    exp_prot  = 1'b0;
    pend_prot = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_resp", bus.m_resp, '0);
    chk("rst_s_req", bus.s_req, '0);
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("prot_err", prot_err, exp_prot);
    if (bus.m_resp[0]) begin
      if (exp_q.size() == 0) begin
        chk("m_resp_unexpected", bus.m_resp, '0);
      end else begin
        logic [RESP_W-1:0] e;
        e = exp_q.pop_front();
        chk("m_resp", bus.m_resp, e);
      end
    end else begin
      chk("m_resp_quiet", bus.m_resp, '0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.m_req  = '0;
    bus.s_resp = '0;
    @(negedge clk);
    chk("por_busy", busy, 1'b0);
    chk("por_state", dbg_state, 2'd0);
    do_reset();

    do_txn(32'h0000_0010, 32'h0, 4'h0, 0, 32'hAABB_CCDD, 1'b0);
    do_txn(32'h4000_0004, 32'h1234, 4'hF, 3, 32'h5A5A_1234, 1'b0);
    idle();
    do_txn(32'hC000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    do_txn(32'h8000_0020, 32'hBEEF, 4'h3, 2, 32'h0BAD_F00D, 1'b1);
    for (int i = 0; i < 10; i++) idle();
    chk("prot_err_sticky", prot_err, 1'b1);
    do_reset();
    chk("prot_err_cleared", prot_err, 1'b0);
    do_txn(32'hC000_0004, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    idle();
    do_reset();

    // Abandon an outstanding request with an asynchronous reset.
    step();
    bus.m_req = {1'b1, 32'h4000_0000, 32'h0, 4'h0};
    set_slots(1, 1'b0, $urandom());
    @(negedge clk);
    chk("mid_accept_busy", busy, 1'b0);
    step();
    bus.m_req = '0;
    set_slots(1, 1'b0, $urandom());
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    do_reset();
    step();
    set_slots(1, 1'b1, 32'hCAFE_F00D);
    @(negedge clk);
    chk("late_ready_busy", busy, 1'b0);
    chk("late_ready_resp", bus.m_resp, '0);
    idle();

    for (int t = 0; t < 300; t++) begin
      logic [AW-1:0] a;
      int  lat;
      bit  inr, viol;
      a    = $urandom();
      lat  = $urandom_range(0, 4);
      inr  = (int'(a[AW-1 -: P]) < N);
      viol = ($urandom_range(0, 24) == 0) && (!inr || lat >= 1);
      do_txn(a, $urandom(), 4'($urandom_range(0, 15)), lat, $urandom(), viol);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle();
      if (viol) begin
        idle();
        do_reset();
      end
    end

    for (int i = 0; i < 3; i++) idle();
    chk("drain_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
